pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter stage of the single-cycle processor. Holds the 8-bit PC and computes PC+step and the branch target. It drives the 8-bit PC-source mux inputs and registers the next PC. A small run-control FSM adds start-up, stall and halt behaviour, and a retired-instruction counter supports debug.

Parameters:
ADDR_W, 8, PC / address width in bits
RESET_PC, 8'h00, PC value loaded on reset
PC_STEP, 4, sequential increment in bytes
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC this cycle (e.g. memory not ready)
branch_taken  in  1  conditional branch resolved taken
branch_offset  in  ADDR_W  signed word offset from sign-extended immediate
jump  in  1  unconditional jump
jump_target  in  ADDR_W  absolute jump address
halt_req  in  1  enter HALT (from halt/illegal-op decode)
resume  in  1  leave HALT
pc  out  ADDR_W  current PC to instruction memory
pc_plus_step  out  ADDR_W  pc + PC_STEP (mux i0 input)
branch_target  out  ADDR_W  pc_plus_step + (branch_offset << 2) (mux i1 input)
fetch_valid  out  1  instruction at pc is to be executed this cycle
halted  out  1  FSM in HALT
retired_cnt  out  CNT_W  number of instructions retired

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=BOOT, fetch_valid=0, halted=0, retired_cnt=0. pc_plus_step and branch_target track pc combinationally.
- Arithmetic: all sums are modulo 2^ADDR_W; wrap-around is silent (8'hFC + 4 = 8'h00). The offset shift is a logical left shift of the ADDR_W-bit offset, discarding the top 2 bits. The sum is two's complement.
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle after reset release; fetch_valid=0; pc is held. The next state is RUN regardless of inputs.
  - RUN: fetch_valid = ~stall.
    - If halt_req=1: the next state is HALT, pc is held, and the instruction is not retired.
    - Else if stall=1: pc is held and retired_cnt is held.
    - Else: the current instruction is retired (retired_cnt+1, saturating at all-ones). The next pc is selected with priority jump > branch_taken > sequential:
      - jump → jump_target
      - branch_taken → branch_target
      - otherwise → pc_plus_step
  - HALT: fetch_valid=0, halted=1, and pc is held. All of stall, jump and branch inputs are ignored. resume=1 moves the next state to RUN. If halt_req and resume are both 1, the block stays in HALT.
- halted is registered and equals 1 iff state==HALT. It asserts in the cycle after the halt_req edge.
- Simultaneous events in RUN: halt_req beats stall, which beats jump, which beats branch. jump and branch_taken both set means jump wins.
- Reset mid-operation: asserting rst_n at any time immediately forces the reset values and BOOT. No partial update is allowed.
- Latency: a PC update is visible on pc one cycle after the deciding inputs are sampled. pc_plus_step and branch_target have zero-cycle combinational latency from pc.
- Non-stalled RUN cycles produce no bubble: one instruction per cycle.

Test Plan:
- Reset/boot: hold rst_n=0, release → pc=8'h00, fetch_valid=0 for 1 cycle. Then pc steps 00,04,08,0C and retired_cnt=3 after 3 RUN cycles.
- Branch: at pc=8'h10, branch_offset=8'hFE (−2), branch_taken=1 → branch_target=8'h0C, next pc=8'h0C. With offset=8'h03 → next pc=8'h20.
- Priority: pc=8'h20, jump=1, jump_target=8'h80, branch_taken=1 → next pc=8'h80. Same inputs with stall=1 → pc stays 8'h20 and retired_cnt unchanged.
- Wrap: pc=8'hFC, no control → next pc=8'h00. branch_offset=8'h01 at pc=8'hF8 → branch_target=8'h00.
- Halt/resume: halt_req=1 at pc=8'h24 → halted=1 next cycle, pc holds 8'h24, fetch_valid=0 for 5 cycles despite jump=1. resume=1 → RUN, pc continues 24,28.
- Async reset mid-run: drop rst_n between clock edges at pc=8'h40, state RUN → pc=8'h00, fetch_valid=0 and retired_cnt=0 immediately, before the next edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, forms PC+step and the branch target,
// and sequences boot/run/halt with a saturating retired-instruction counter.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_step,
    output logic [ADDR_W-1:0] branch_target,
    output logic              fetch_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_halted;
    logic [CNT_W-1:0]    r_cnt;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                w_retire;
    logic [ADDR_W-1:0]   w_pc_plus_step;
    logic [ADDR_W-1:0]   w_off_sh;
    logic [ADDR_W-1:0]   w_branch_target;

    // Word offset to byte offset; top two offset bits fall off, sums wrap.
    assign w_pc_plus_step  = r_pc + ADDR_W'(PC_STEP);
    assign w_off_sh        = {branch_offset[ADDR_W-3:0], 2'b00};
    assign w_branch_target = w_pc_plus_step + w_off_sh;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_retire    = 1'b0;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (!stall) begin
                    w_retire = 1'b1;
                    if (jump)              w_pc_nxt = jump_target;
                    else if (branch_taken) w_pc_nxt = w_branch_target;
                    else                   w_pc_nxt = w_pc_plus_step;
                end
            end
            S_HALT: begin
                // halt_req wins over a simultaneous resume.
                if (resume && !halt_req) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_BOOT;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= (w_state_nxt == S_HALT);
            if (w_retire && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign pc            = r_pc;
    assign pc_plus_step  = w_pc_plus_step;
    assign branch_target = w_branch_target;
    assign fetch_valid   = (r_state == S_RUN) && !stall;
    assign halted        = r_halted;
    assign retired_cnt   = r_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus random stimulus for pc_fetch_unit, checked every cycle
// against an arithmetic reference model of the PC stage.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, halt_req, resume;
    logic [7:0]  branch_offset, jump_target;
    logic [7:0]  pc, pc_plus_step, branch_target;
    logic        fetch_valid, halted;
    logic [15:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    // reference model
    bit m_boot, m_halt;
    int m_pc, m_cnt;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .halt_req(halt_req), .resume(resume), .pc(pc), .pc_plus_step(pc_plus_step),
        .branch_target(branch_target), .fetch_valid(fetch_valid), .halted(halted),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_pc = 0; m_cnt = 0;
    endtask

    // Drive inputs just after a posedge, check at the negedge, then advance the model.
    task automatic cyc(input bit s, input bit bt, input logic [7:0] bo,
                       input bit j, input logic [7:0] jt, input bit h, input bit r);
        stall = s; branch_taken = bt; branch_offset = bo;
        jump = j; jump_target = jt; halt_req = h; resume = r;
        #4;
        check("pc",        32'(pc),            32'(m_pc));
        check("pc_plus",   32'(pc_plus_step),  32'((m_pc + 4) % 256));
        check("br_target", 32'(branch_target), 32'((m_pc + 4 + int'(bo) * 4) % 256));
        check("fetch_vld", 32'(fetch_valid),   32'(!m_boot && !m_halt && !s));
        check("halted",    32'(halted),        32'(m_halt));
        check("retired",   32'(retired_cnt),   32'(m_cnt));
        @(posedge clk);
        if (m_boot) m_boot = 0;
        else if (m_halt) begin
            if (r && !h) m_halt = 0;
        end else if (h) m_halt = 1;
        else if (!s) begin
            if (m_cnt < 65535) m_cnt++;
            if (j)       m_pc = int'(jt);
            else if (bt) m_pc = (m_pc + 4 + int'(bo) * 4) % 256;
            else         m_pc = (m_pc + 4) % 256;
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic go(input logic [7:0] t);
        cyc(0, 0, 8'h00, 1, t, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; branch_taken = 0; branch_offset = 0;
        jump = 0; jump_target = 0; halt_req = 0; resume = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pc",  32'(pc),          32'h00);
        check("rst_fv",  32'(fetch_valid), 32'h0);
        check("rst_hlt", 32'(halted),      32'h0);
        check("rst_cnt", 32'(retired_cnt), 32'h0);
        rst_n = 1'b1;

        // boot cycle then 00,04,08,0C
        idle(); idle(); idle(); idle();
        check("boot_pc",  32'(pc),          32'h0C);
        check("boot_cnt", 32'(retired_cnt), 32'd3);

        // branches
        go(8'h10);
        cyc(0, 1, 8'hFE, 0, 8'h00, 0, 0);
        check("br_back", 32'(pc), 32'h0C);
        go(8'h10);
        cyc(0, 1, 8'h03, 0, 8'h00, 0, 0);
        check("br_fwd", 32'(pc), 32'h20);

        // stall beats jump, jump beats branch
        cyc(1, 1, 8'h05, 1, 8'h80, 0, 0);
        check("stall_pc", 32'(pc), 32'h20);
        cyc(0, 1, 8'h05, 1, 8'h80, 0, 0);
        check("jmp_pri", 32'(pc), 32'h80);

        // wrap-around
        go(8'hFC);
        idle();
        check("wrap_seq", 32'(pc), 32'h00);
        go(8'hF8);
        cyc(0, 0, 8'h01, 0, 8'h00, 0, 0);

        // halt with jump ignored, halt_req beats resume, then resume
        go(8'h24);
        cyc(1, 0, 8'h00, 1, 8'h90, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h07, 1, 8'h90, 0, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 1, 1);
        check("hold_hlt", 32'(halted), 32'h1);
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 1);
        idle(); idle();
        check("resume_pc", 32'(pc), 32'h2C);

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 8'($urandom),
                $urandom_range(0, 4) == 0, 8'($urandom),
                $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);

        // async reset between edges while running
        cyc(0, 0, 8'h00, 0, 8'h00, 0, 1);
        go(8'h40);
        idle();
        stall = 0; jump = 0; branch_taken = 0; halt_req = 0; resume = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc",  32'(pc),          32'h00);
        check("async_fv",  32'(fetch_valid), 32'h0);
        check("async_cnt", 32'(retired_cnt), 32'h0);
        check("async_hlt", 32'(halted),      32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        idle(); idle(); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
